// File: rtl/enc_store_pkg.sv
// enc_store_pkg: shared cipher functions, rotation helpers and width derivation for the encrypted store
package enc_store_pkg;
  localparam int MAX_W = 256;
  typedef enum logic {ENC, DEC} cipher_mode_e;
  function automatic int clog2_fn(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction
  // Rotations work inside a MAX_W container; only the low w bits take part.
  function automatic logic [MAX_W-1:0] rotl_fn(input logic [MAX_W-1:0] x, input int r, input int w);
    logic [MAX_W-1:0] y;
    logic [7:0] j;
    y = '0;
    for (int i = 0; i < MAX_W; i++) begin
      j = 8'((i + r) % w);
      if (i < w) y[j] = x[i];
    end
    return y;
  endfunction
  function automatic logic [MAX_W-1:0] rotr_fn(input logic [MAX_W-1:0] x, input int r, input int w);
    logic [MAX_W-1:0] y;
    logic [7:0] j;
    y = '0;
    for (int i = 0; i < MAX_W; i++) begin
      j = 8'((i + r) % w);
      if (i < w) y[i] = x[j];
    end
    return y;
  endfunction
  function automatic logic [MAX_W-1:0] enc_fn(input logic [MAX_W-1:0] pt, key, pad, input int r, input int w);
    return rotl_fn(pt ^ key, r, w) ^ pad;
  endfunction
  function automatic logic [MAX_W-1:0] dec_fn(input logic [MAX_W-1:0] ct, key, pad, input int r, input int w);
    return rotr_fn(ct ^ pad, r, w) ^ key;
  endfunction
endpackage

// File: rtl/enc_store_cipher.sv
// enc_store_cipher: combinational address-keyed rotate/xor cipher, enciphering or deciphering by MODE
module enc_store_cipher
  import enc_store_pkg::*;
#(
  parameter cipher_mode_e MODE = ENC,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14
) (
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] key,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout
);
  localparam int ROT_W = clog2_fn(DATA_W);
  assign dout = DATA_W'(MODE == ENC
    ? enc_fn(MAX_W'(din), MAX_W'(key), MAX_W'(addr), int'(addr[ROT_W-1:0]), DATA_W)
    : dec_fn(MAX_W'(din), MAX_W'(key), MAX_W'(addr), int'(addr[ROT_W-1:0]), DATA_W));
endmodule

// File: rtl/enc_store_mem_v3.sv
// enc_store_mem_v3: encrypted word store with loadable key table, per-word key tag, written bitmap
// and a 2-stage read pipeline returning own-key and caller-key deciphered words
module enc_store_mem_v3
  import enc_store_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int DEPTH = 16384,
  parameter int KEY_SLOTS = 4,
  parameter logic [DATA_W-1:0] KEY_INIT = '0,
  localparam int KSEL_W = clog2_fn(KEY_SLOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KSEL_W-1:0] wr_key_sel,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [KSEL_W-1:0] rd_key_sel,
  input  logic              key_wr_en,
  input  logic [KSEL_W-1:0] key_wr_idx,
  input  logic [DATA_W-1:0] key_wr_data,
  output logic [DATA_W-1:0] real_data,
  output logic [DATA_W-1:0] wrong_real_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_addr_q,
  output logic              rd_unwritten,
  output logic              key_mismatch
);
  localparam int MW = DATA_W + KSEL_W;
  logic [DATA_W-1:0] keys [KEY_SLOTS];
  logic [MW-1:0] mem [DEPTH];
  logic [DEPTH-1:0] written;
  logic [DATA_W-1:0] wr_enc, own_dec, sel_dec, s1_word;
  logic [KSEL_W-1:0] s1_tag, s1_ksel;
  logic [ADDR_W-1:0] s1_addr;
  logic s1_valid, s1_hit, wr_ok, rd_ok;
  assign wr_ok = wr_en && (32'(wr_addr) < DEPTH);
  assign rd_ok = 32'(rd_addr) < DEPTH;
  enc_store_cipher #(.MODE(ENC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_enc (
    .din(wr_data), .key(keys[wr_key_sel]), .addr(wr_addr), .dout(wr_enc)
  );
  enc_store_cipher #(.MODE(DEC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dec_own (
    .din(s1_word), .key(keys[s1_tag]), .addr(s1_addr), .dout(own_dec)
  );
  enc_store_cipher #(.MODE(DEC), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_dec_sel (
    .din(s1_word), .key(keys[s1_ksel]), .addr(s1_addr), .dout(sel_dec)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < KEY_SLOTS; i++) keys[i] <= KEY_INIT;
    end else if (key_wr_en) begin
      keys[key_wr_idx] <= key_wr_data;
    end
  end
  // RAM kept free of reset so it maps onto block memory; reads are read-first.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= {wr_key_sel, wr_enc};
    if (rd_en) {s1_tag, s1_word} <= mem[rd_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      written <= '0;
      s1_valid <= 1'b0;
      s1_hit <= 1'b0;
      s1_addr <= '0;
      s1_ksel <= '0;
    end else begin
      if (wr_ok) written[wr_addr] <= 1'b1;
      s1_valid <= rd_en;
      if (rd_en) begin
        s1_addr <= rd_addr;
        s1_ksel <= rd_key_sel;
        s1_hit <= rd_ok && written[rd_addr];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      real_data <= '0;
      wrong_real_data <= '0;
      rd_addr_q <= '0;
      rd_unwritten <= 1'b0;
      key_mismatch <= 1'b0;
    end else begin
      rd_valid <= s1_valid;
      if (s1_valid) begin
        rd_addr_q <= s1_addr;
        rd_unwritten <= !s1_hit;
        real_data <= s1_hit ? own_dec : '0;
        wrong_real_data <= s1_hit ? sel_dec : '0;
        key_mismatch <= s1_hit && (s1_ksel != s1_tag);
      end
    end
  end
endmodule

// File: tb/tb_enc_store_mem_v3.sv
// tb_enc_store_mem_v3: scoreboard bench; reads push expected responses, a negedge monitor pops and compares
module tb_enc_store_mem_v3;
  logic clk = 0, rst = 1;
  logic wr_en = 0, rd_en = 0, key_wr_en = 0;
  logic [13:0] wr_addr = 0, rd_addr = 0;
  logic [63:0] wr_data = 0, key_wr_data = 0;
  logic [1:0] wr_key_sel = 0, rd_key_sel = 0, key_wr_idx = 0;
  logic [63:0] real_data, wrong_real_data;
  logic rd_valid, rd_unwritten, key_mismatch;
  logic [13:0] rd_addr_q;
  logic [65:0] peek;
  int passed = 0, total = 0;
  typedef struct {logic [13:0] addr; logic unw; logic [63:0] real_d; logic [63:0] wrong_d; logic mis;} exp_t;
  exp_t q[$];
  enc_store_mem_v3 dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_key_sel(wr_key_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_key_sel(rd_key_sel), .key_wr_en(key_wr_en),
    .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data), .real_data(real_data),
    .wrong_real_data(wrong_real_data), .rd_valid(rd_valid), .rd_addr_q(rd_addr_q),
    .rd_unwritten(rd_unwritten), .key_mismatch(key_mismatch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 0;
    rd_en = 0;
    key_wr_en = 0;
  endtask
  task automatic wr(input logic [13:0] a, input logic [63:0] d, input logic [1:0] ks);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    wr_key_sel = ks;
  endtask
  task automatic kload(input logic [1:0] idx, input logic [63:0] d);
    key_wr_en = 1;
    key_wr_idx = idx;
    key_wr_data = d;
  endtask
  task automatic rd(input logic [13:0] a, input logic [1:0] ks, input logic unw,
                    input logic [63:0] r, input logic [63:0] w, input logic m);
    exp_t e;
    rd_en = 1;
    rd_addr = a;
    rd_key_sel = ks;
    e.addr = a; e.unw = unw; e.real_d = r; e.wrong_d = w; e.mis = m;
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rd_valid", 64'(rd_addr_q), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rd_addr_q", 64'(rd_addr_q), 64'(e.addr));
        chk("rd_unwritten", 64'(rd_unwritten), 64'(e.unw));
        chk("real_data", real_data, e.real_d);
        chk("wrong_real_data", wrong_real_data, e.wrong_d);
        chk("key_mismatch", 64'(key_mismatch), 64'(e.mis));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, pending %0d", q.size());
    $fatal(1, "timeout");
  end
  initial begin
    repeat (10) @(posedge clk);
    #1 rst = 0;
    chk("reset_rd_valid", 64'(rd_valid), 0);
    chk("reset_real_data", real_data, 0);
    chk("reset_wrong_data", wrong_real_data, 0);
    chk("reset_rd_addr_q", 64'(rd_addr_q), 0);
    chk("reset_flags", 64'({rd_unwritten, key_mismatch}), 0);
    rd(7, 0, 1, 0, 0, 0); step();
    kload(1, 64'hFF); step();
    wr(1, 10, 1); step();
    peek = dut.mem[1];
    chk("stored_word_addr1", peek[63:0], 64'h1EB);
    rd(1, 1, 0, 10, 10, 0); step();
    kload(2, 64'h1234); step();
    wr(2, 20, 2); step();
    rd(2, 0, 0, 20, 64'h1220, 1); step();
    wr(3, 5, 0); step();
    wr(3, 30, 0); rd(3, 0, 0, 5, 5, 0); step();
    rd(3, 0, 0, 30, 30, 0); step();
    rd(1, 0, 0, 10, 64'hF5, 1); step();
    rd(2, 0, 0, 20, 64'h1220, 1); step();
    rd(3, 0, 0, 30, 30, 0); step();
    wr(4, 7, 3); kload(3, 64'hAA); step();
    rd(4, 3, 0, 64'hAD, 64'hAD, 0); step();
    kload(3, 64'h55); step();
    rd(4, 3, 0, 64'h52, 64'h52, 0); step();
    repeat (3) step();
    rd_en = 1; rd_addr = 1; rd_key_sel = 0; step();
    rst = 1; step();
    rst = 0;
    chk("flush_rd_valid_0", 64'(rd_valid), 0);
    step();
    chk("flush_rd_valid_1", 64'(rd_valid), 0);
    rd(1, 0, 1, 0, 0, 0); step();
    wr(5, 10, 0); step();
    rd(5, 1, 0, 10, 10, 1); step();
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("scoreboard_drained", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
